// File: rtl/video_scan_controller.sv
// Apple II/e character-cell video scan controller.
// Generates the 14M/7M phase, the H/V scan counters, the display-memory
// address for each cell, and the strobes the shift-register path consumes.
// Every output is a flop; the per-cell outputs are reloaded at the edge
// that enters P=0, computed from the next H/V values and the mode inputs
// present at that edge, so they hold steady for the entire cell.
module video_scan_controller #(
    parameter int H_TOTAL      = 65,
    parameter int H_VIS_START  = 25,
    parameter int V_TOTAL      = 262,
    parameter int V_VIS        = 192,
    parameter int FLASH_FRAMES = 16
) (
    input  logic        CLK_14M,
    input  logic        reset,
    input  logic        TEXT_MODE,
    input  logic        MIXED_MODE,
    input  logic        HIRES_MODE,
    input  logic        PAGE2,
    output logic        CLK_7M,
    output logic        LDPS_N,
    output logic        WNDW_N,
    output logic        SEGA,
    output logic        SEGB,
    output logic        SEGC,
    output logic        GR2,
    output logic        FLASH_CLK,
    output logic [15:0] VADDR,
    output logic        HBL,
    output logic        VBL
);

    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [3:0]    P_LAST = 4'd13;
    localparam logic [7:0]    H_LAST = 8'(H_TOTAL - 1);
    localparam logic [7:0]    H_VS   = 8'(H_VIS_START);
    localparam logic [8:0]    V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0]    V_VS   = 9'(V_VIS);
    // First line of the four text rows kept as text in mixed mode.
    localparam logic [8:0]    V_MIX  = 9'd160;
    localparam logic [FW-1:0] F_LAST = FW'(FLASH_FRAMES - 1);

    // Scan state
    logic [3:0]    p_q, p_d;
    logic [7:0]    h_q, h_d;
    logic [8:0]    v_q, v_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    // Registered outputs
    logic          clk7_q, ldps_n_q, wndw_n_q, gr2_q, flash_q, hbl_q, vbl_q;
    logic [2:0]    seg_q;
    logic [15:0]   vaddr_q;

    // Per-cell values for the cell being entered
    logic          p_wrap, h_wrap, v_wrap;
    logic          flash_d;
    logic          hbl_n, vbl_n, gr2_n;
    logic [6:0]    col;
    logic [15:0]   row_off, grp_off, base_off, vaddr_n;

    // Counter chain P -> H -> V -> flash frame count.
    always_comb begin
        p_wrap  = (p_q == P_LAST);
        h_wrap  = p_wrap && (h_q == H_LAST);
        v_wrap  = h_wrap && (v_q == V_LAST);

        p_d     = p_wrap ? 4'd0 : p_q + 4'd1;
        h_d     = h_q;
        v_d     = v_q;
        fcnt_d  = fcnt_q;
        flash_d = flash_q;

        if (p_wrap)
            h_d = (h_q == H_LAST) ? 8'd0 : h_q + 8'd1;
        if (h_wrap)
            v_d = (v_q == V_LAST) ? 9'd0 : v_q + 9'd1;
        if (v_wrap) begin
            if (fcnt_q == F_LAST) begin
                fcnt_d  = '0;
                flash_d = ~flash_q;
            end else begin
                fcnt_d  = fcnt_q + 1'b1;
            end
        end
    end

    // Blanking, graphics select and display address for the next cell.
    // Column wraps modulo 128 during blanking; the address is don't-care
    // there but stays a pure function of H/V/mode.
    always_comb begin
        hbl_n   = (h_d < H_VS);
        vbl_n   = (v_d >= V_VS);
        gr2_n   = ~TEXT_MODE & ~(MIXED_MODE & (v_d >= V_MIX));
        col     = 7'(h_d - H_VS);
        row_off = {6'b0, v_d[5:3], 7'b0};
        // V[7:6] * 0x28 as (x*32 + x*8)
        grp_off = {9'b0, v_d[7:6], 5'b0} + {11'b0, v_d[7:6], 3'b0};
        if (gr2_n && HIRES_MODE)
            base_off = {1'b0, PAGE2, ~PAGE2, v_d[2:0], 10'b0};
        else
            base_off = {4'b0, PAGE2, ~PAGE2, 10'b0};
        vaddr_n = base_off + row_off + grp_off + {9'b0, col};
    end

    // State and output registers; per-cell outputs load only entering P=0.
    always_ff @(posedge CLK_14M) begin
        if (reset) begin
            p_q      <= 4'd0;
            h_q      <= 8'd0;
            v_q      <= 9'd0;
            fcnt_q   <= '0;
            clk7_q   <= 1'b0;
            ldps_n_q <= 1'b1;
            wndw_n_q <= 1'b1;
            seg_q    <= 3'd0;
            gr2_q    <= 1'b0;
            flash_q  <= 1'b0;
            vaddr_q  <= 16'h0000;
            hbl_q    <= 1'b1;
            vbl_q    <= 1'b0;
        end else begin
            p_q      <= p_d;
            h_q      <= h_d;
            v_q      <= v_d;
            fcnt_q   <= fcnt_d;
            flash_q  <= flash_d;
            clk7_q   <= p_d[0];
            // Low across P=12..13 so the single load lands at P=12.
            ldps_n_q <= ~((p_d == 4'd12) || (p_d == 4'd13));
            if (p_wrap) begin
                hbl_q    <= hbl_n;
                vbl_q    <= vbl_n;
                wndw_n_q <= hbl_n | vbl_n;
                seg_q    <= v_d[2:0];
                gr2_q    <= gr2_n;
                vaddr_q  <= vaddr_n;
            end
        end
    end

    assign CLK_7M    = clk7_q;
    assign LDPS_N    = ldps_n_q;
    assign WNDW_N    = wndw_n_q;
    assign SEGA      = seg_q[0];
    assign SEGB      = seg_q[1];
    assign SEGC      = seg_q[2];
    assign GR2       = gr2_q;
    assign FLASH_CLK = flash_q;
    assign VADDR     = vaddr_q;
    assign HBL       = hbl_q;
    assign VBL       = vbl_q;

endmodule

// File: tb/tb_video_scan_controller.sv
// Scoreboard bench for video_scan_controller. Three instances run side by
// side: full geometry, a 2-cell-wide line with full vertical geometry (fast
// access to late lines), and a tiny frame for the flash divider.
module tb_video_scan_controller;

    typedef struct {
        int          ep;
        int          k;
        int          sel;
        logic [15:0] v;
        string       nm;
    } item_t;

    localparam int S_CLK7 = 0, S_LDPS = 1, S_WNDW = 2, S_SEG = 3, S_GR2 = 4,
                   S_FLASH = 5, S_VADDR = 6, S_HBL = 7, S_VBL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   [3];
    logic text  [3];
    logic mixed [3];
    logic hires [3];
    logic page2 [3];

    wire [25:0] ow0, ow1, ow2;
    logic [25:0] obs [3];
    assign obs[0] = ow0;
    assign obs[1] = ow1;
    assign obs[2] = ow2;

    int  kc [3];
    int  epc [3];
    bit  rst_d [3];
    item_t sbq [3][$];

    int tests = 0;
    int fails = 0;

    video_scan_controller u_a (
        .CLK_14M(clk), .reset(rst[0]), .TEXT_MODE(text[0]), .MIXED_MODE(mixed[0]),
        .HIRES_MODE(hires[0]), .PAGE2(page2[0]),
        .CLK_7M(ow0[0]), .LDPS_N(ow0[1]), .WNDW_N(ow0[2]), .SEGA(ow0[3]), .SEGB(ow0[4]),
        .SEGC(ow0[5]), .GR2(ow0[6]), .FLASH_CLK(ow0[7]), .HBL(ow0[8]), .VBL(ow0[9]),
        .VADDR(ow0[25:10]));

    video_scan_controller #(.H_TOTAL(2), .H_VIS_START(1)) u_b (
        .CLK_14M(clk), .reset(rst[1]), .TEXT_MODE(text[1]), .MIXED_MODE(mixed[1]),
        .HIRES_MODE(hires[1]), .PAGE2(page2[1]),
        .CLK_7M(ow1[0]), .LDPS_N(ow1[1]), .WNDW_N(ow1[2]), .SEGA(ow1[3]), .SEGB(ow1[4]),
        .SEGC(ow1[5]), .GR2(ow1[6]), .FLASH_CLK(ow1[7]), .HBL(ow1[8]), .VBL(ow1[9]),
        .VADDR(ow1[25:10]));

    video_scan_controller #(.H_TOTAL(2), .H_VIS_START(1), .V_TOTAL(4), .V_VIS(2)) u_c (
        .CLK_14M(clk), .reset(rst[2]), .TEXT_MODE(text[2]), .MIXED_MODE(mixed[2]),
        .HIRES_MODE(hires[2]), .PAGE2(page2[2]),
        .CLK_7M(ow2[0]), .LDPS_N(ow2[1]), .WNDW_N(ow2[2]), .SEGA(ow2[3]), .SEGB(ow2[4]),
        .SEGC(ow2[5]), .GR2(ow2[6]), .FLASH_CLK(ow2[7]), .HBL(ow2[8]), .VBL(ow2[9]),
        .VADDR(ow2[25:10]));

    function automatic logic [15:0] pick(input logic [25:0] o, input int sel);
        case (sel)
            S_CLK7:  return {15'b0, o[0]};
            S_LDPS:  return {15'b0, o[1]};
            S_WNDW:  return {15'b0, o[2]};
            S_SEG:   return {13'b0, o[5:3]};
            S_GR2:   return {15'b0, o[6]};
            S_FLASH: return {15'b0, o[7]};
            S_HBL:   return {15'b0, o[8]};
            S_VBL:   return {15'b0, o[9]};
            default: return o[25:10];
        endcase
    endfunction

    // Cycle index since reset release and reset epoch, per instance.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rst[g]) begin
                kc[g] <= 0;
                if (!rst_d[g]) epc[g] <= epc[g] + 1;
            end else begin
                kc[g] <= kc[g] + 1;
            end
            rst_d[g] <= rst[g];
        end
    end

    // Monitor: pop and compare every expectation due at this cycle.
    always @(negedge clk) begin : monb
        item_t it;
        logic [15:0] got;
        for (int g = 0; g < 3; g++) begin
            while (sbq[g].size() > 0 && sbq[g][0].ep == epc[g] && sbq[g][0].k == kc[g]) begin
                it  = sbq[g].pop_front();
                got = pick(obs[g], it.sel);
                tests++;
                if (got !== it.v) begin
                    fails++;
                    $display("FAIL %s inst%0d ep%0d k%0d: got %h expected %h",
                             it.nm, g, it.ep, it.k, got, it.v);
                end
            end
        end
    end

    task automatic ex(input int g, input int e, input int k, input int sel,
                      input logic [15:0] v, input string nm);
        item_t it;
        it.ep = e; it.k = k; it.sel = sel; it.v = v; it.nm = nm;
        sbq[g].push_back(it);
    endtask

    task automatic ex_reset(input int g, input int e);
        ex(g, e, 0, S_CLK7,  16'h0, "rst_clk7");
        ex(g, e, 0, S_LDPS,  16'h1, "rst_ldps");
        ex(g, e, 0, S_WNDW,  16'h1, "rst_wndw");
        ex(g, e, 0, S_SEG,   16'h0, "rst_seg");
        ex(g, e, 0, S_GR2,   16'h0, "rst_gr2");
        ex(g, e, 0, S_FLASH, 16'h0, "rst_flash");
        ex(g, e, 0, S_VADDR, 16'h0, "rst_vaddr");
        ex(g, e, 0, S_HBL,   16'h1, "rst_hbl");
        ex(g, e, 0, S_VBL,   16'h0, "rst_vbl");
    endtask

    task automatic wait_k(input int g, input int e, input int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(epc[g] == e && kc[g] == t) && n < 200000);
        if (n >= 200000) begin
            tests++;
            fails++;
            $display("FAIL wait inst%0d ep%0d k%0d: timed out", g, e, t);
        end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst[g] = 1'b1; text[g] = 1'b1; mixed[g] = 1'b0;
            hires[g] = 1'b0; page2[g] = 1'b0;
        end

        // Instance A: full geometry
        ex_reset(0, 1);
        for (int k = 1; k <= 14; k++) begin
            ex(0, 1, k, S_CLK7, 16'(k % 2), "clk7_seq");
            ex(0, 1, k, S_LDPS, (k == 12 || k == 13) ? 16'h0 : 16'h1, "ldps_seq");
        end
        ex(0, 1, 349,  S_WNDW,  16'h1,    "pre_vis_wndw");
        ex(0, 1, 349,  S_HBL,   16'h1,    "pre_vis_hbl");
        ex(0, 1, 350,  S_WNDW,  16'h0,    "h25_wndw");
        ex(0, 1, 350,  S_HBL,   16'h0,    "h25_hbl");
        ex(0, 1, 350,  S_VADDR, 16'h0400, "h25_vaddr");
        ex(0, 1, 350,  S_GR2,   16'h0,    "h25_gr2");
        ex(0, 1, 350,  S_SEG,   16'h0,    "h25_seg");
        ex(0, 1, 363,  S_VADDR, 16'h0400, "h25_end_vaddr");
        ex(0, 1, 896,  S_VADDR, 16'h0427, "h64_vaddr");
        ex(0, 1, 896,  S_WNDW,  16'h0,    "h64_wndw");
        ex(0, 1, 910,  S_WNDW,  16'h1,    "line1_h0_wndw");
        ex(0, 1, 910,  S_HBL,   16'h1,    "line1_h0_hbl");
        ex(0, 1, 910,  S_SEG,   16'h1,    "line1_seg");
        ex(0, 1, 1330, S_VADDR, 16'h0405, "v1h30_vaddr");
        ex(0, 1, 1340, S_VADDR, 16'h0405, "midcell_hold");
        ex(0, 1, 1344, S_VADDR, 16'h0806, "page2_next_cell");
        ex(0, 1, 1358, S_VADDR, 16'h0407, "page2_restored");
        ex(0, 1, 8610, S_VADDR, 16'h4485, "hires_vaddr");
        ex(0, 1, 8610, S_GR2,   16'h1,    "hires_gr2");
        ex(0, 1, 8610, S_SEG,   16'h1,    "hires_seg");
        ex(0, 1, 8624, S_VADDR, 16'h0886, "lores_vaddr");
        ex(0, 1, 8624, S_GR2,   16'h1,    "lores_gr2");
        ex(0, 1, 9665, S_VADDR, 16'h088F, "prerst_vaddr");
        ex(0, 1, 9665, S_WNDW,  16'h0,    "prerst_wndw");
        ex(0, 1, 9665, S_CLK7,  16'h1,    "prerst_clk7");
        ex_reset(0, 2);
        ex(0, 2, 1,  S_CLK7, 16'h1, "rel_clk7");
        ex(0, 2, 11, S_LDPS, 16'h1, "rel_ldps11");
        ex(0, 2, 12, S_LDPS, 16'h0, "rel_ldps12");
        ex(0, 2, 12, S_CLK7, 16'h0, "rel_clk7_12");
        ex(0, 2, 13, S_LDPS, 16'h0, "rel_ldps13");
        ex(0, 2, 14, S_LDPS, 16'h1, "rel_ldps14");

        // Instance B: 2-cell lines, full vertical geometry
        ex(1, 1, 1806, S_VADDR, 16'h0428, "v64_vaddr");
        ex(1, 1, 1806, S_SEG,   16'h0,    "v64_seg");
        ex(1, 1, 2002, S_SEG,   16'h7,    "v71_seg");
        ex(1, 1, 2002, S_VADDR, 16'h0428, "v71_vaddr");
        ex(1, 1, 4466, S_GR2,   16'h1,    "v159_gr2");
        ex(1, 1, 4466, S_VADDR, 16'h05D0, "v159_vaddr");
        ex(1, 1, 4480, S_GR2,   16'h0,    "v160h0_gr2");
        ex(1, 1, 4494, S_GR2,   16'h0,    "v160_gr2");
        ex(1, 1, 4494, S_VADDR, 16'h0650, "v160_vaddr");
        ex(1, 1, 4494, S_WNDW,  16'h0,    "v160_wndw");
        ex(1, 1, 5362, S_WNDW,  16'h0,    "v191_wndw");
        ex(1, 1, 5362, S_VBL,   16'h0,    "v191_vbl");
        ex(1, 1, 5376, S_VBL,   16'h1,    "v192h0_vbl");
        ex(1, 1, 5376, S_WNDW,  16'h1,    "v192h0_wndw");
        ex(1, 1, 5390, S_VBL,   16'h1,    "v192_vbl");
        ex(1, 1, 5390, S_WNDW,  16'h1,    "v192_wndw");
        ex(1, 1, 5390, S_HBL,   16'h0,    "v192_hbl");
        ex(1, 1, 7322, S_VBL,   16'h1,    "v261_vbl");
        ex(1, 1, 7322, S_SEG,   16'h5,    "v261_seg");
        ex(1, 1, 7336, S_VBL,   16'h0,    "vwrap_vbl");
        ex(1, 1, 7336, S_SEG,   16'h0,    "vwrap_seg");
        ex(1, 1, 7336, S_WNDW,  16'h1,    "vwrap_wndw");
        ex(1, 1, 7336, S_FLASH, 16'h0,    "vwrap_flash");
        ex(1, 1, 7350, S_WNDW,  16'h0,    "v0_wndw");
        ex(1, 1, 7350, S_GR2,   16'h1,    "v0_mixed_gr2");
        ex(1, 1, 7350, S_VADDR, 16'h0400, "v0_vaddr");

        // Instance C: 112-cycle frames, flash divider
        ex(2, 1, 0,    S_FLASH, 16'h0, "c_rst_flash");
        ex(2, 1, 56,   S_VBL,   16'h1, "c_vbl");
        ex(2, 1, 1791, S_FLASH, 16'h0, "flash_before");
        ex(2, 1, 1792, S_FLASH, 16'h1, "flash_toggle1");
        ex(2, 1, 3583, S_FLASH, 16'h1, "flash_hold");
        ex(2, 1, 3584, S_FLASH, 16'h0, "flash_toggle2");

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) rst[g] = 1'b0;

        fork
            begin
                wait_k(0, 1, 1335); page2[0] = 1'b1;
                wait_k(0, 1, 1350); page2[0] = 1'b0;
                wait_k(0, 1, 8600); text[0] = 1'b0; hires[0] = 1'b1; page2[0] = 1'b1;
                wait_k(0, 1, 8615); hires[0] = 1'b0;
                wait_k(0, 1, 9665); rst[0] = 1'b1;
                repeat (3) @(negedge clk);
                rst[0] = 1'b0;
                wait_k(0, 2, 20);
            end
            begin
                wait_k(1, 1, 4200); text[1] = 1'b0; mixed[1] = 1'b1;
                wait_k(1, 1, 7360);
            end
            begin
                wait_k(2, 1, 3590);
            end
        join

        repeat (10) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            while (sbq[g].size() > 0) begin
                item_t it;
                it = sbq[g].pop_front();
                tests++;
                fails++;
                $display("FAIL %s inst%0d ep%0d k%0d: never observed", it.nm, g, it.ep, it.k);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/video_scan_controller.md
Name: video_scan_controller

Overview:
- Sequences the Apple II/e character-cell video datapath.
- Generates the 14M/7M phase, the horizontal and vertical scan counters, the display-memory address for each character cell, and the control strobes the video shift register path consumes: LDPS_N, WNDW_N, SEGA/B/C, GR2 and FLASH_CLK.
- Sits between the soft-switch/mode register block and the video ROM/shift-register generator.

Parameters:
- H_TOTAL, 65, character cells per scan line.
- H_VIS_START, 25, first visible cell index; visible cells are H_VIS_START..H_TOTAL-1 (40 cells).
- V_TOTAL, 262, scan lines per frame.
- V_VIS, 192, visible lines, 0..V_VIS-1.
- FLASH_FRAMES, 16, frames per FLASH_CLK half-period.

Ports:
- CLK_14M  in  1  master clock, 14.31818 MHz.
- reset  in  1  synchronous, active-high reset.
- TEXT_MODE  in  1  1 = text mode.
- MIXED_MODE  in  1  1 = bottom 4 text rows shown as text while in graphics.
- HIRES_MODE  in  1  1 = hi-res graphics (when not text).
- PAGE2  in  1  selects display page 2.
- CLK_7M  out  1  7 MHz phase, high on odd phases.
- LDPS_N  out  1  shift-register load strobe, active low.
- WNDW_N  out  1  low while the current cell is inside the visible window.
- SEGA  out  1  video ROM row-select bit 0 (V[0]).
- SEGB  out  1  video ROM row-select bit 1 (V[1]).
- SEGC  out  1  video ROM row-select bit 2 (V[2]).
- GR2  out  1  graphics (non-text) select for the current line.
- FLASH_CLK  out  1  flashing-text clock.
- VADDR  out  16  display-memory byte address for the current cell.
- HBL  out  1  horizontal blank.
- VBL  out  1  vertical blank.

Behaviour:
- Phase counter P runs 0..13 and wraps to 0; one character cell is 14 CLK_14M cycles. No stretched cycle.
- CLK_7M = P[0], registered. It is 0 when P is even.
- H counter runs 0..H_TOTAL-1 and increments when P wraps from 13 to 0.
- V counter runs 0..V_TOTAL-1 and increments when H wraps. V wraps to 0 after V_TOTAL-1.
- All outputs are registered. Reset values:
  - P=0, H=0, V=0, CLK_7M=0.
  - LDPS_N=1, WNDW_N=1, SEGA/B/C=0, GR2=0, FLASH_CLK=0, VADDR=0x0000.
  - HBL=1, VBL=0.
  - Flash frame counter = 0.
- Reset asserted mid-line or mid-frame returns every state to these values on the next edge. Counting restarts from P=0, H=0, V=0 on the first cycle after reset deasserts.
- Mode sampling: mode inputs are sampled once per cell, at the transition into P=0. Their effect appears on VADDR/GR2 from that cycle for the entire cell. A mode change mid-cell has no effect until the next cell.
- At P=0 of each cell the following are updated:
  - HBL = (H < H_VIS_START).
  - VBL = (V >= V_VIS).
  - WNDW_N = HBL | VBL.
  - SEGA/B/C = V[2:0].
  - GR2 = ~TEXT_MODE & ~(MIXED_MODE & V >= 160).
- Column: col = H - H_VIS_START, 0..39, used only when visible.
- VADDR when GR2=0 or lo-res: 0x0400 + PAGE2*0x0400 + V[5:3]*0x80 + V[7:6]*0x28 + col.
- VADDR when GR2=1 and HIRES_MODE=1: 0x2000 + PAGE2*0x2000 + V[2:0]*0x400 + V[5:3]*0x80 + V[7:6]*0x28 + col.
- VADDR arithmetic is unsigned, 16-bit, no overflow possible.
- During blanking VADDR is still computed with col = H - H_VIS_START mod 2^16 truncated to 7 bits. The value is don't-care but must be deterministic. The bench checks VADDR only when WNDW_N=0.
- LDPS_N is low during P=12 and P=13 of every cell, high otherwise. The downstream load therefore occurs exactly once per cell, on the edge where CLK_7M=0 and P=12.
- DL must be valid by P=12; the memory path has 12 cycles from VADDR update.
- FLASH_CLK: the frame counter increments when V wraps to 0. When it reaches FLASH_FRAMES-1 and V wraps, it clears and FLASH_CLK toggles.

Test Plan:
- Release reset, run 14 cycles -> CLK_7M sequence 0,1,0,1...; LDPS_N low exactly at P=12,13; H advances 0->1 at cycle 14.
- Run to H=25, V=0, TEXT_MODE=1, PAGE2=0 -> WNDW_N=0, HBL=0, VADDR=0x0400, GR2=0; at H=64 VADDR=0x0427; at H=0 of the next line WNDW_N=1.
- TEXT_MODE=1, V=64 (row 8), H=25 -> VADDR=0x0428, SEGA/B/C=000; at V=71, SEG=111.
- TEXT_MODE=0, HIRES_MODE=1, PAGE2=1, V=9, H=30 -> VADDR=0x4000+1*0x400+1*0x80+0+5=0x4485, GR2=1.
- TEXT_MODE=0, MIXED_MODE=1 -> GR2=1 at V=159 and GR2=0 at V=160; V=192 -> VBL=1, WNDW_N=1; V wraps 261->0.
- Run 16 frames -> FLASH_CLK 0->1 at the wrap after frame 15; assert reset at H=40, V=100 -> next cycle all outputs at reset values; first LDPS_N low 12 cycles after release.
